// File: rtl/rename_free_list.sv
// Physical-tag free list for the rename stage: circular tag buffer with one branch checkpoint.
// Define FREE_LIST_CHECK_EN to build the sticky overflow/underflow checker that drives err.
module rename_free_list #(
  parameter int VIRT_COUNT      = 256,
  parameter int VIRT_ADDR_WIDTH = $clog2(VIRT_COUNT),
  parameter int ARCH_COUNT      = 32,
  parameter int ALLOC_PORTS     = 4,
  parameter int FREE_PORTS      = 4
) (
  input  logic                                           clk,
  input  logic                                           sync_rst,
  input  logic                                           clk_en,
  input  logic [ALLOC_PORTS-1:0]                         alloc_req,
  input  logic                                           alloc_valid,
  output logic                                           alloc_ready,
  output logic [ALLOC_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]    alloc_tag,
  input  logic [FREE_PORTS-1:0]                          free_en,
  input  logic [FREE_PORTS-1:0][VIRT_ADDR_WIDTH-1:0]     free_tag,
  input  logic                                           ckpt_take,
  input  logic                                           ckpt_restore,
  output logic [VIRT_ADDR_WIDTH:0]                       free_count,
  output logic                                           err
);
  localparam int W = VIRT_ADDR_WIDTH;
  typedef logic [W:0] ptr_t;
  typedef enum logic {IDLE, CKPT_VALID} ckpt_state_t;

  logic [W-1:0] entries [VIRT_COUNT];
  ptr_t         head, tail, saved_head;
  ckpt_state_t  state;

  ptr_t             k, nfree, head_fire, head_nxt;
  ptr_t             alloc_off [ALLOC_PORTS];
  ptr_t             free_off  [FREE_PORTS];
  logic [FREE_PORTS-1:0] free_acc;
  logic             fire, restore_ok;

  assign free_count = tail - head;

  // Prefix counts give each requesting port its slot relative to head.
  always_comb begin
    k = '0;
    for (int p = 0; p < ALLOC_PORTS; p++) begin
      alloc_off[p] = k;
      k = k + ptr_t'(alloc_req[p]);
    end
  end

  assign alloc_ready = (free_count >= k) && !ckpt_restore;
  assign fire        = clk_en && alloc_valid && alloc_ready;
  assign head_fire   = fire ? head + k : head;
  assign restore_ok  = ckpt_restore && (state == CKPT_VALID);
  assign head_nxt    = restore_ok ? saved_head : head_fire;

  for (genvar p = 0; p < ALLOC_PORTS; p++) begin : g_alloc
    ptr_t rd_ptr;
    assign rd_ptr       = head + alloc_off[p];
    assign alloc_tag[p] = alloc_req[p] ? entries[rd_ptr[W-1:0]] : '0;
  end

`ifdef FREE_LIST_CHECK_EN
  localparam logic [W-1:0] ARCH_TAG = W'(ARCH_COUNT);
  localparam ptr_t         FC_INIT  = ptr_t'(VIRT_COUNT - ARCH_COUNT);
  int   room, nreq;
  logic err_q, overflow, underflow, arch_bad;

  // Frees beyond the remaining capacity are dropped rather than corrupting live entries.
  always_comb begin
    room = VIRT_COUNT - int'(ptr_t'(tail - head_nxt));
    nreq = 0;
    arch_bad = 1'b0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      free_acc[p] = free_en[p] && (nreq < room);
      nreq = nreq + int'(free_en[p]);
      if (free_en[p] && (free_tag[p] < ARCH_TAG) && (free_count == FC_INIT))
        arch_bad = 1'b1;
    end
  end

  assign overflow  = (free_acc != free_en);
  assign underflow = fire && (k > free_count);

  always_ff @(posedge clk) begin
    if (sync_rst)
      err_q <= 1'b0;
    else if (clk_en && (overflow || underflow || arch_bad))
      err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign free_acc = free_en;
  assign err      = 1'b0;
`endif

  always_comb begin
    nfree = '0;
    for (int p = 0; p < FREE_PORTS; p++) begin
      free_off[p] = nfree;
      nfree = nfree + ptr_t'(free_acc[p]);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < VIRT_COUNT; i++)
        entries[i] <= W'(i + ARCH_COUNT);
      head       <= '0;
      tail       <= ptr_t'(VIRT_COUNT - ARCH_COUNT);
      saved_head <= '0;
      state      <= IDLE;
    end else if (clk_en) begin
      head <= head_nxt;
      tail <= tail + nfree;
      for (int p = 0; p < FREE_PORTS; p++) begin
        if (free_acc[p]) entries[W'(tail + free_off[p])] <= free_tag[p];
      end
      // Restore has priority over take; a take alongside a restore is discarded.
      if (ckpt_restore) begin
        state <= IDLE;
      end else if (ckpt_take) begin
        saved_head <= head_fire;
        state      <= CKPT_VALID;
      end
    end
  end
endmodule
